// File: rtl/mem_delayed_multi.sv
// mem_delayed_multi: shared word-addressed memory serving NUM_PORTS requestors with fixed latency and round-robin arbitration
module mem_delayed_multi #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4096,
  parameter int LATENCY   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*32-1:0]     addr,
  input  logic [NUM_PORTS-1:0]        rd_req,
  input  logic [NUM_PORTS-1:0]        wr_req,
  input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
  output logic [NUM_PORTS*DATA_W-1:0] rd_data,
  output logic [NUM_PORTS-1:0]        busy,
  output logic [NUM_PORTS-1:0]        ack,
  input  logic [31:0]                 oob_wr_addr,
  input  logic [DATA_W-1:0]           oob_wr_data,
  input  logic                        oob_wen
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(LATENCY) + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        gnt_q, gnt_d, ptr_q, ptr_d, sel;
  logic [NUM_PORTS-1:0] pend_q, pend_d, wr_q, wr_d, acc;
  logic [31:0]          paddr_q [NUM_PORTS];
  logic [31:0]          paddr_d [NUM_PORTS];
  logic [DATA_W-1:0]    pdata_q [NUM_PORTS];
  logic [DATA_W-1:0]    pdata_d [NUM_PORTS];
  logic [DATA_W-1:0]    rd_q    [NUM_PORTS];
  logic [DATA_W-1:0]    rd_d    [NUM_PORTS];
  logic [DATA_W-1:0]    mem     [DEPTH];
  logic                 found, do_acc, g_oor, oob_oor;
  logic [31:0]          g_addr;
  logic [AW-1:0]        g_idx, oob_idx;
  assign g_addr  = paddr_q[gnt_q];
  assign g_oor   = (g_addr >> 2) >= 32'(DEPTH);
  assign g_idx   = g_addr[AW+1:2];
  assign oob_oor = (oob_wr_addr >> 2) >= 32'(DEPTH);
  assign oob_idx = oob_wr_addr[AW+1:2];
  assign ack     = state_q == DONE ? NUM_PORTS'(1) << gnt_q : '0;
  assign busy    = pend_q & ~ack;
  assign acc     = ~busy & (rd_req | wr_req);
  assign do_acc  = state_q == WAIT && cnt_q == '0;
  // per-port pending slots: a request is captured only when the port is idle (including its ack cycle)
  always_comb begin
    pend_d = busy | acc;
    wr_d   = (acc & wr_req) | (~acc & wr_q);
    for (int p = 0; p < NUM_PORTS; p++) begin
      paddr_d[p] = acc[p] ? addr[32*p +: 32] : paddr_q[p];
      pdata_d[p] = acc[p] ? wr_data[DATA_W*p +: DATA_W] : pdata_q[p];
      rd_d[p]    = (do_acc && gnt_q == PW'(p) && !wr_q[p]) ? (g_oor ? '0 : mem[g_idx]) : rd_q[p];
      rd_data[DATA_W*p +: DATA_W] = rd_q[p];
    end
  end
  // engine: round-robin grant in IDLE, count down the latency in WAIT, single-cycle ack in DONE
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++)
      if (!found && pend_q[(int'(ptr_q) + k) % NUM_PORTS]) begin
        sel   = PW'((int'(ptr_q) + k) % NUM_PORTS);
        found = 1'b1;
      end
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = WAIT;
        cnt_d   = CW'(LATENCY - 1);
        gnt_d   = sel;
        ptr_d   = sel;
      end
      WAIT: begin
        state_d = cnt_q == '0 ? DONE : WAIT;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // control and read-data registers, cleared by asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= PW'(NUM_PORTS - 1);
      pend_q  <= '0;
      wr_q    <= '0;
      paddr_q <= '{default: '0};
      pdata_q <= '{default: '0};
      rd_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      rd_q    <= rd_d;
    end
  end
  // storage survives reset; preload works during reset, and the engine write is ordered last so it wins a same-index collision
  always_ff @(posedge clk) begin
    if (oob_wen && !oob_oor) mem[oob_idx] <= oob_wr_data;
    if (do_acc && wr_q[gnt_q] && !g_oor && !rst) mem[g_idx] <= pdata_q[gnt_q];
  end
endmodule

// File: tb/tb_mem_delayed_multi.sv
// tb_mem_delayed_multi: directed self-checking bench for mem_delayed_multi
module tb_mem_delayed_multi;
  logic        clk, rst;
  logic [63:0] addr, wr_data, rd_data, rd_data_s;
  logic [1:0]  rd_req, wr_req, busy, ack, busy_s, ack_s;
  logic [31:0] oob_wr_addr, oob_wr_data;
  logic        oob_wen;
  int          n_tests = 0, n_fail = 0, lat;

  mem_delayed_multi #(.NUM_PORTS(2), .DATA_W(32), .DEPTH(4096), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .ack(ack),
    .oob_wr_addr(oob_wr_addr), .oob_wr_data(oob_wr_data), .oob_wen(oob_wen));

  mem_delayed_multi #(.NUM_PORTS(2), .DATA_W(32), .DEPTH(16), .LATENCY(4)) dut_s (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
    .rd_data(rd_data_s), .busy(busy_s), .ack(ack_s),
    .oob_wr_addr(oob_wr_addr), .oob_wr_data(oob_wr_data), .oob_wen(oob_wen));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    addr[32*p +: 32]    = a;
    wr_data[32*p +: 32] = d;
    if (w) wr_req[p] = 1'b1;
    else   rd_req[p] = 1'b1;
  endtask

  task automatic wait_ack(input int p, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        rd_req = '0;
        wr_req = '0;
      end
    end while (!ack[p] && n < 40);
  endtask

  initial begin
    rst = 1'b1; rd_req = '0; wr_req = '0; addr = '0; wr_data = '0;
    oob_wen = 1'b0; oob_wr_addr = '0; oob_wr_data = '0;
    @(negedge clk); oob_wen = 1'b1; oob_wr_addr = 32'h100; oob_wr_data = 32'hDEADBEEF;
    @(negedge clk); oob_wr_addr = 32'h0;  oob_wr_data = 32'h5A5A5A5A;
    @(negedge clk); oob_wr_addr = 32'h8;  oob_wr_data = 32'h0;
    @(negedge clk); oob_wen = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset ack", ack, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset rd_data small", rd_data_s, 0);
    rst = 1'b0;
    @(negedge clk);
    // preloaded read with exact busy/ack timing
    issue(0, 0, 32'h100, 0);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) rd_req = '0;
      chk("t1 busy", busy, n < 6 ? 2'b01 : 2'b00);
      chk("t1 ack", ack, n == 6 ? 2'b01 : 2'b00);
    end
    chk("t1 rd_data", rd_data[31:0], 32'hDEADBEEF);
    // write then aliased readback on port 1
    issue(1, 1, 32'h20, 32'h12345678); wait_ack(1, lat);
    chk("t2 wr latency", lat, 6);
    chk("t2 rd_data after wr", rd_data[63:32], 0);
    issue(1, 0, 32'h23, 0); wait_ack(1, lat);
    chk("t2 rd latency", lat, 6);
    chk("t2 readback", rd_data[63:32], 32'h12345678);
    issue(1, 1, 32'h24, 32'hCAFEF00D); wait_ack(1, lat);
    chk("t2 rd_data held", rd_data[63:32], 32'h12345678);
    // contention; port0 re-requests in its ack cycle and port1 must win the next grant
    issue(0, 0, 32'h100, 0); issue(1, 0, 32'h20, 0);
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 1 || n == 7) rd_req = '0;
      chk("t3 ack", ack, n == 6 || n == 18 ? 2'b01 : n == 12 ? 2'b10 : 2'b00);
      if (n == 6) issue(0, 0, 32'h100, 0);
    end
    chk("t3 rd_data", rd_data, {32'h12345678, 32'hDEADBEEF});
    // out-of-range on the 16-word instance
    issue(0, 0, 32'h0, 0); wait_ack(0, lat);
    chk("t4 small mem0 before", rd_data_s[31:0], 32'h5A5A5A5A);
    issue(0, 1, 32'h40, 32'hFF); wait_ack(0, lat);
    chk("t4 oor wr ack", ack_s, 2'b01);
    issue(0, 0, 32'h40, 0); wait_ack(0, lat);
    chk("t4 oor rd ack", ack_s, 2'b01);
    chk("t4 oor rd data", rd_data_s[31:0], 0);
    chk("t4 big in-range data", rd_data[31:0], 32'hFF);
    issue(0, 0, 32'h0, 0); wait_ack(0, lat);
    chk("t4 small mem0 after", rd_data_s[31:0], 32'h5A5A5A5A);
    // request while busy is ignored; new request in ack cycle is accepted
    issue(0, 0, 32'h20, 0);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1 || n == 7) rd_req = '0;
      if (n == 3) begin addr[31:0] = 32'h20; wr_data[31:0] = 32'hBAD; wr_req = 2'b01; end
      if (n == 4) wr_req = '0;
      chk("t5 ack", ack, n == 6 || n == 12 ? 2'b01 : 2'b00);
      if (n == 6) begin
        chk("t5 no write", rd_data[31:0], 32'h12345678);
        issue(0, 0, 32'h24, 0);
      end
    end
    chk("t5 second read", rd_data[31:0], 32'hCAFEF00D);
    // reset in the middle of a write
    issue(0, 1, 32'h8, 32'hAA);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 1) wr_req = '0;
    end
    rst = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      chk("t6 ack in reset", ack, 0);
      chk("t6 busy in reset", busy, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    issue(0, 0, 32'h8, 0); wait_ack(0, lat);
    chk("t6 rd latency", lat, 6);
    chk("t6 abandoned write", rd_data[31:0], 0);
    // engine vs oob at the same edge: same index then different index
    for (int r = 0; r < 2; r++) begin
      issue(0, 1, r == 0 ? 32'h30 : 32'h38, r == 0 ? 32'h11111111 : 32'h44444444);
      for (int n = 1; n <= 6; n++) begin
        @(negedge clk);
        if (n == 1) wr_req = '0;
        if (n == 5) begin oob_wen = 1'b1; oob_wr_addr = r == 0 ? 32'h30 : 32'h3C; oob_wr_data = r == 0 ? 32'h22222222 : 32'h55555555; end
        if (n == 6) begin oob_wen = 1'b0; chk("t6 coll ack", ack, 2'b01); end
      end
    end
    issue(0, 0, 32'h30, 0); wait_ack(0, lat);
    chk("t6 engine wins", rd_data[31:0], 32'h11111111);
    issue(0, 0, 32'h38, 0); wait_ack(0, lat);
    chk("t6 engine diff idx", rd_data[31:0], 32'h44444444);
    issue(0, 0, 32'h3C, 0); wait_ack(0, lat);
    chk("t6 oob diff idx", rd_data[31:0], 32'h55555555);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_delayed_multi.md
Name: mem_delayed_multi

Overview:
- Parametrised successor to the single-port delayed memory model.
- Serves NUM_PORTS independent requestors (processor cores, DMA) from one shared word-addressed array, with a configurable access latency and round-robin arbitration.
- The out-of-band (oob) preload write port is retained.
- Sits under the top-level compute wrapper, between the core array and the memory model.

Parameters:
NUM_PORTS, 2, number of requestor channels (1..8)
DATA_W, 32, data word width
DEPTH, 4096, number of words in the array
LATENCY, 4, cycles from grant to ack (>=1)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
addr  input  NUM_PORTS*32  per-port byte address; port p at [32p+31:32p]
rd_req  input  NUM_PORTS  per-port read request pulse
wr_req  input  NUM_PORTS  per-port write request pulse
wr_data  input  NUM_PORTS*DATA_W  per-port write data
rd_data  output  NUM_PORTS*DATA_W  per-port read data, registered
busy  output  NUM_PORTS  port has an accepted request outstanding
ack  output  NUM_PORTS  one-cycle completion pulse per port
oob_wr_addr  input  32  oob byte address
oob_wr_data  input  DATA_W  oob write data
oob_wen  input  1  oob write enable

Behaviour:
- Reset (async, rst=1): busy=0, ack=0, rd_data=0. All pending flags cleared. Engine returns to IDLE. Round-robin pointer = NUM_PORTS-1, so port 0 wins first.
- Memory contents are not cleared by reset. oob writes are honoured while rst=1, to allow program preload.
- Word index = addr[log2(DEPTH)+1:2]. Low 2 bits are ignored.
- Out-of-range addresses (addr>>2 >= DEPTH):
  - read returns 0;
  - write is dropped;
  - ack is still given.
- Request acceptance: at a rising edge where busy[p]=0 and (rd_req[p] | wr_req[p]), the port latches addr, wr_data and op into its pending slot. busy[p]=1 from the next cycle.
  - rd_req and wr_req both high: treated as a write.
  - Requests while busy[p]=1 are ignored; they are not queued.
- Engine states:
  - IDLE: if any port is pending, grant the first pending port after the round-robin pointer (wrapping modulo NUM_PORTS). Load counter = LATENCY-1, update pointer = granted port, go to WAIT. The grant happens in the same cycle busy first rises.
  - WAIT: decrement the counter. When counter==0, perform the access and go to DONE.
    - Read: rd_data[p] <= mem[idx].
    - Write: mem[idx] <= data.
  - DONE: ack[p]=1 and busy[p]=0 for exactly this cycle. Clear pending[p]. Return to IDLE.
- IDLE->WAIT is not combined with DONE, so back-to-back grants have one idle cycle.
- Uncontended latency: request sampled at edge t, busy high cycles t+1..t+LATENCY+1, ack high at cycle t+LATENCY+2, at which point busy=0.
- A port may issue a new request in its ack cycle. It is accepted at that edge.
- rd_data[p] holds its value until the next read ack on port p. Write acks leave it unchanged.
- Only one port is acked per cycle. ack bits are one-hot or zero.
- Simultaneous engine write and oob write to the same index at the same edge: the engine write wins. Different indices: both commit.
- oob writes to out-of-range addresses are dropped.
- Reads see oob writes committed at earlier edges.
- Reset mid-transaction: the access is abandoned. A write not yet committed does not reach memory. No ack is produced.

Test Plan:
1. oob preload, then single read: oob write 0x100<=0xDEADBEEF with rst=1. Release rst. Port0 rd_req addr 0x100 at edge t, LATENCY=4 → ack[0] at t+6, rd_data[0]=0xDEADBEEF, busy[0] high t+1..t+5.
2. Write/readback with byte-offset aliasing: port1 writes 0x12345678 to 0x20, then reads 0x23 → rd_data[1]=0x12345678. rd_data[1] is unchanged by the write ack.
3. Contention: port0 and port1 request in the same cycle. Port0 is acked first, then port1 exactly LATENCY+2 cycles later. On the next simultaneous pair, port1 wins (round-robin), with NUM_PORTS=2.
4. Out-of-range access: DEPTH=16. Write 0xFF to addr 0x40, then read 0x40 → both acked, read returns 0, and mem[0] is untouched.
5. Request while busy: port0 issues a read, then pulses wr_req mid-WAIT → only one ack, no write committed. A new request in the ack cycle is accepted.
6. Reset mid-write: assert rst during WAIT of a write of 0xAA to 0x8 → after reset, a read of 0x8 returns the old value (0), with no ack during reset. Also check engine/oob same-index collision → engine data is stored.
